prbs_pattern_gen: RTL
=====================

// Module: prbs_pattern_gen
// PURPOSE
//  Parametrised successor to the fixed 4-byte/PRBS-15 generator: streams a preamble pattern
//  REPS times, then an LFSR sequence of selectable polynomial, over a valid/ready stream.
//  Sits between the link control logic (start/config) and the serializer/TX datapath.
// PARAMETERS
//  PAT_BYTES  4   preamble pattern length in bytes (1..16)
//  OUT_W      8   output beat width in bits; PAT_BYTES*8 % OUT_W == 0; OUT_W in {8,16,32}
//  CNT_W      8   width of rep_cnt
//  LEN_W      16  width of prbs_len
// PORTS
//  clk        in   1              clock, all state on rising edge
//  rst        in   1              asynchronous, active-low reset
//  start      in   1              begin a run; honoured only in IDLE
//  abort      in   1              terminate the run; to IDLE on the next edge
//  pat_in     in   PAT_BYTES*8    preamble; byte 0 = pat_in[7:0], sent first
//  rep_cnt    in   CNT_W          preamble repetitions (0 = skip preamble)
//  prbs_sel   in   2              0:PRBS7 x^7+x^6+1  1:PRBS15 x^15+x^14+1  2:PRBS23 x^23+x^18+1  3:PRBS31 x^31+x^28+1
//  prbs_len   in   LEN_W          PRBS beats before done (0 = endless)
//  out_data   out  OUT_W          beat data
//  out_valid  out  1              beat present
//  out_ready  in   1              sink accepts; transfer = out_valid & out_ready
//  busy       out  1              high in any state except IDLE
//  done       out  1              1-cycle pulse after the last PRBS beat transfers
// BEHAVIOUR
//  Reset: state IDLE, out_data=0, out_valid=0, busy=0, done=0, LFSR=all ones, counters 0.
//  States: IDLE -> PAT (start & rep_cnt!=0) | PRBS (start & rep_cnt==0);
//    PAT -> PRBS after last beat of repetition rep_cnt transfers; PRBS -> IDLE after beat
//    prbs_len transfers (done=1 that cycle+1); abort in any state -> IDLE, no done, LFSR reseeded.
//  start at edge t captures pat_in/rep_cnt/prbs_sel/prbs_len; first beat valid from cycle t+1.
//  Config inputs ignored while busy; start while busy ignored.
//  Beat k of pattern = pat_in[k*OUT_W +: OUT_W]; beat index wraps to 0 each repetition.
//  Hold rule: while out_valid & !out_ready, out_data and all counters/LFSR frozen.
//  No bubbles: with out_ready held high one beat transfers every cycle, including PAT->PRBS.
//  LFSR: 31-bit register, degree D from prbs_sel uses s[D-1:0]; per bit fb=s[D-1]^s[tap-1],
//    s<={s[D-2:0],fb}; emitted bit = fb; out_data[0] = earliest bit; OUT_W steps per beat.
//  LFSR seeded all ones at reset, at run start and on abort; first PRBS beat uses the seed.
//  prbs_len==0: PRBS endless until abort; beat counter saturates, never wraps to done.
//  Counter widths: repetition counter CNT_W, beat counter LEN_W; no overflow arithmetic.
//  Reset mid-run: immediate IDLE, out_valid drops asynchronously.
// CONFIGURATION
//  PRBS_ERR_INJ_EN defined: adds port err_inj (in,1); a pulse arms a one-shot flag that
//    inverts out_data[0] of the next PRBS beat transferred; flag clears on that transfer,
//    abort or reset; pulses in PAT stay armed until PRBS. Multiple pulses before use = one error.
//  Undefined: port absent, PRBS stream never modified.
// STRUCTURE
//  Package prbs_pkg: state enum (IDLE,PAT,PRBS), prbs_sel encodings, per-mode degree/tap
//    constants, LFSR_SEED (31'h7FFF_FFFF), LFSR_MAX_W=31.
//  Sub-module prbs_lfsr: holds LFSR state, inputs sel/adv/reseed, outputs next OUT_W bits;
//    advances OUT_W steps when adv. Top holds FSM, counters, pattern mux, handshake.
// TESTING
//  PAT_BYTES=4, pat_in=32'hDDCCBBAA, rep_cnt=2, prbs_sel=1, ready=1 -> AA BB CC DD AA BB CC DD
//    then PRBS15 beats 00, 40; busy high throughout.
//  rep_cnt=0, prbs_sel=1, prbs_len=3 -> three PRBS beats 00,40,.. then done pulse, busy=0, IDLE.
//  Backpressure: drop out_ready for 5 cycles mid-pattern -> out_data/out_valid held, no beat lost.
//  abort during PRBS then restart same config -> stream restarts from AA, LFSR from seed, no done.
//  rst low during PAT -> out_valid=0, busy=0 immediately; after release idle until start.
//  PRBS_ERR_INJ_EN: err_inj during PAT -> first PRBS beat 01 instead of 00, later beats unchanged.

Source files
------------

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared state encoding, polynomial table and LFSR constants for prbs_pattern_gen
package prbs_pkg;

    typedef enum logic [1:0] {IDLE, PAT, PRBS} state_t;

    localparam logic [1:0] SEL_PRBS7  = 2'd0;
    localparam logic [1:0] SEL_PRBS15 = 2'd1;
    localparam logic [1:0] SEL_PRBS23 = 2'd2;
    localparam logic [1:0] SEL_PRBS31 = 2'd3;

    localparam logic [4:0] DEG_PRBS7  = 5'd7;
    localparam logic [4:0] TAP_PRBS7  = 5'd6;
    localparam logic [4:0] DEG_PRBS15 = 5'd15;
    localparam logic [4:0] TAP_PRBS15 = 5'd14;
    localparam logic [4:0] DEG_PRBS23 = 5'd23;
    localparam logic [4:0] TAP_PRBS23 = 5'd18;
    localparam logic [4:0] DEG_PRBS31 = 5'd31;
    localparam logic [4:0] TAP_PRBS31 = 5'd28;

    localparam int LFSR_MAX_W = 31;
    localparam logic [LFSR_MAX_W-1:0] LFSR_SEED = 31'h7FFF_FFFF;

    function automatic logic [4:0] prbs_deg(input logic [1:0] sel);
        case (sel)
            SEL_PRBS7:  prbs_deg = DEG_PRBS7;
            SEL_PRBS15: prbs_deg = DEG_PRBS15;
            SEL_PRBS23: prbs_deg = DEG_PRBS23;
            SEL_PRBS31: prbs_deg = DEG_PRBS31;
        endcase
    endfunction

    function automatic logic [4:0] prbs_tap(input logic [1:0] sel);
        case (sel)
            SEL_PRBS7:  prbs_tap = TAP_PRBS7;
            SEL_PRBS15: prbs_tap = TAP_PRBS15;
            SEL_PRBS23: prbs_tap = TAP_PRBS23;
            SEL_PRBS31: prbs_tap = TAP_PRBS31;
        endcase
    endfunction

endpackage

// File: rtl/prbs_pattern_gen_if.sv
// prbs_pattern_gen_if: valid/ready beat stream from the generator to the TX datapath
interface prbs_pattern_gen_if #(
    parameter int OUT_W = 8
);
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/prbs_lfsr.sv
// prbs_lfsr: Fibonacci LFSR of selectable degree, presents the next OUT_W output bits
module prbs_lfsr
    import prbs_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sel,
    input  logic             adv,
    input  logic             reseed,
    output logic [OUT_W-1:0] bits
);

    logic [LFSR_MAX_W-1:0] s_q;
    logic [LFSR_MAX_W-1:0] s_n;
    logic [4:0]            deg;
    logic [4:0]            tap;

    assign deg = prbs_deg(sel);
    assign tap = prbs_tap(sel);

    // Unroll OUT_W single-bit steps; bit 0 of the beat is the earliest emitted bit
    always_comb begin
        s_n  = s_q;
        bits = '0;
        for (int i = 0; i < OUT_W; i++) begin
            bits[i] = s_n[deg - 5'd1] ^ s_n[tap - 5'd1];
            s_n     = {s_n[LFSR_MAX_W-2:0], bits[i]};
        end
    end

    // Register state: seed on reset/reseed, step a whole beat only on a PRBS transfer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            s_q <= LFSR_SEED;
        else if (reseed)
            s_q <= LFSR_SEED;
        else if (adv)
            s_q <= s_n;
    end

endmodule

// File: rtl/prbs_pattern_gen.sv
// prbs_pattern_gen: preamble pattern repeated rep_cnt times then PRBS stream; optional PRBS_ERR_INJ_EN adds err_inj
module prbs_pattern_gen
    import prbs_pkg::*;
#(
    parameter int PAT_BYTES = 4,
    parameter int OUT_W     = 8,
    parameter int CNT_W     = 8,
    parameter int LEN_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [PAT_BYTES*8-1:0] pat_in,
    input  logic [CNT_W-1:0]       rep_cnt,
    input  logic [1:0]             prbs_sel,
    input  logic [LEN_W-1:0]       prbs_len,
    prbs_pattern_gen_if.master     tx,
    output logic                   busy,
    output logic                   done
`ifdef PRBS_ERR_INJ_EN
    ,
    input  logic                   err_inj
`endif
);

    localparam int NB    = PAT_BYTES * 8 / OUT_W;
    localparam int IDX_W = NB > 1 ? $clog2(NB) : 1;

    state_t                 state_q;
    state_t                 state_d;
    logic                   done_d;
    logic [PAT_BYTES*8-1:0] pat_q;
    logic [CNT_W-1:0]       reps_q;
    logic [CNT_W-1:0]       rep_q;
    logic [1:0]             sel_q;
    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   xfer;
    logic                   launch;
    logic                   pat_end;
    logic                   rep_end;
    logic                   prbs_end;
    logic                   adv;
    logic                   reseed;
    logic [OUT_W-1:0]       lfsr_bits;
    logic [OUT_W-1:0]       prbs_beat;

    assign xfer     = tx.out_valid & tx.out_ready;
    assign launch   = state_q == IDLE && start && !abort;
    assign pat_end  = idx_q == IDX_W'(NB - 1);
    assign rep_end  = rep_q == reps_q - CNT_W'(1);
    assign prbs_end = len_q != '0 && cnt_q == len_q - LEN_W'(1);
    assign adv      = state_q == PRBS && xfer && !abort;
    assign reseed   = abort || launch;

    prbs_lfsr #(.OUT_W(OUT_W)) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .sel    (sel_q),
        .adv    (adv),
        .reseed (reseed),
        .bits   (lfsr_bits)
    );

    // State register and the one-cycle done pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
        end
    end

    // Next state: abort wins everywhere, PAT hands over to PRBS on the last beat's transfer
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (abort)
            state_d = IDLE;
        else
            case (state_q)
                IDLE: if (start) state_d = rep_cnt != '0 ? PAT : PRBS;
                PAT:  if (xfer && pat_end && rep_end) state_d = PRBS;
                PRBS: if (xfer && prbs_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = IDLE;
            endcase
    end

    // Capture config at launch, then step beat/repetition/PRBS counters only on transfers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q  <= '0;
            reps_q <= '0;
            sel_q  <= '0;
            len_q  <= '0;
            idx_q  <= '0;
            rep_q  <= '0;
            cnt_q  <= '0;
        end else if (launch) begin
            pat_q  <= pat_in;
            reps_q <= rep_cnt;
            sel_q  <= prbs_sel;
            len_q  <= prbs_len;
            idx_q  <= '0;
            rep_q  <= '0;
            cnt_q  <= '0;
        end else if (abort) begin
            idx_q  <= '0;
            rep_q  <= '0;
            cnt_q  <= '0;
        end else if (xfer && state_q == PAT) begin
            idx_q  <= pat_end ? '0 : idx_q + 1'b1;
            rep_q  <= !pat_end ? rep_q : rep_end ? '0 : rep_q + 1'b1;
        end else if (xfer && state_q == PRBS) begin
            cnt_q  <= prbs_end ? '0 : cnt_q == '1 ? cnt_q : cnt_q + 1'b1;
        end
    end

`ifdef PRBS_ERR_INJ_EN
    logic err_q;

    // One-shot error flag: any pulse arms it, the next PRBS transfer consumes it, abort drops it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_q <= 1'b0;
        else
            err_q <= !abort && (err_inj || (err_q && !adv));
    end

    assign prbs_beat = lfsr_bits ^ OUT_W'(err_q);
`else
    assign prbs_beat = lfsr_bits;
`endif

    assign busy          = state_q != IDLE;
    assign tx.out_valid  = busy;
    assign tx.out_data   = state_q == PAT  ? pat_q[idx_q*OUT_W +: OUT_W] :
                           state_q == PRBS ? prbs_beat : '0;

endmodule
